// File: rtl/ucie_ctl_pkg.sv
// ucie_ctl_pkg
//   Shared types and constants for the UCIe TX control/data arbiter and the
//   weighted round-robin picker, which the RX credit scheduler also uses.
//   - arb_state_t : arbiter FSM encoding (IDLE/DATA/CTL)
//   - UCIE_ACTIVE : FDI pl_state_sts encoding for the Active link state
//   - beat_cnt_w  : width of a beat counter that must hold 0..flit_beats-1
//   - wcnt_w      : width of a weight counter that must hold 0..weight
package ucie_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_CTL  = 2'b10
  } arb_state_t;

  localparam logic [3:0] UCIE_ACTIVE = 4'b0001;

  function automatic int beat_cnt_w(input int flit_beats);
    return $clog2(flit_beats) + 1;
  endfunction

  function automatic int wcnt_w(input int weight);
    // weight is at least 1, so this is never narrower than one bit
    return $clog2(weight + 1);
  endfunction

endpackage

// File: rtl/ucie_ctl_wrr_pick.sv
// ucie_ctl_wrr_pick
//   Combinational weighted round-robin choice between a data requester and a
//   control requester. Data wins until DATA_WEIGHT consecutive data grants
//   have been made with control waiting; control then wins once and the
//   weight counter restarts.
//   Ports:
//     data_req, ctl_req : pending requests
//     wcnt              : data grants made while control was pending
//     grant_data        : data wins this decision
//     grant_ctl         : control wins this decision
//     wcnt_nxt          : counter value to store if the decision is taken
module ucie_ctl_wrr_pick #(
  parameter int DATA_WEIGHT = 3,
  parameter int WCNT_W      = 2
) (
  input  logic              data_req,
  input  logic              ctl_req,
  input  logic [WCNT_W-1:0] wcnt,
  output logic              grant_data,
  output logic              grant_ctl,
  output logic [WCNT_W-1:0] wcnt_nxt
);

  localparam logic [WCNT_W-1:0] WEIGHT = WCNT_W'(DATA_WEIGHT);

  always_comb begin
    grant_data = 1'b0;
    grant_ctl  = 1'b0;
    wcnt_nxt   = wcnt;
    if (data_req && ctl_req) begin
      if (wcnt < WEIGHT) begin
        grant_data = 1'b1;
        wcnt_nxt   = wcnt + WCNT_W'(1);
      end else begin
        grant_ctl = 1'b1;
        wcnt_nxt  = '0;
      end
    end else if (data_req) begin
      // Data alone does not count against the weight: nobody is waiting.
      grant_data = 1'b1;
    end else if (ctl_req) begin
      grant_ctl = 1'b1;
      wcnt_nxt  = '0;
    end
  end

endmodule

// File: rtl/ucie_ctl_tx_arbiter.sv
// ucie_ctl_tx_arbiter
//   Shares the RDI transmit mainband between TX FIFO data flits and
//   link-management control flits. Whole flits are granted (no interleave),
//   with weighted round-robin so control cannot be starved. Arbitration only
//   runs while the FDI link state is Active; leaving Active gates all RDI
//   outputs at once and aborts any flit in progress.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     i_fdi_pl_state_sts   : FDI link state
//     i_data_rempty/rdata  : TX FIFO read side (head beat), o_data_rinc pops
//     i_ctl_valid/data     : control beat source, o_ctl_ready accepts
//     i_rdi_pl_trdy        : RDI ready
//     o_rdi_lp_valid/irdy  : RDI beat valid (irdy mirrors valid)
//     o_rdi_lp_data        : RDI beat, zero whenever valid is low
//     o_grant_ctl          : a control flit owns RDI
//     o_flit_abort         : one-cycle pulse after a flit was cut by link exit
//     o_dbg_state          : current FSM state, for observation only
//
//   Handshake: a beat moves on RDI in any cycle where o_rdi_lp_valid and
//   i_rdi_pl_trdy are both 1. That same cycle pops the FIFO (o_data_rinc)
//   or accepts the control beat (o_ctl_ready & i_ctl_valid); valid never
//   depends on trdy, and only the owning source is ever looked at.
module ucie_ctl_tx_arbiter
  import ucie_ctl_pkg::*;
#(
  parameter int          DATA_W      = 64,
  parameter int          FLIT_BEATS  = 4,
  parameter int          DATA_WEIGHT = 3,
  parameter logic [3:0]  UCIE_ACTIVE = ucie_ctl_pkg::UCIE_ACTIVE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        i_fdi_pl_state_sts,
  input  logic              i_data_rempty,
  input  logic [DATA_W-1:0] i_data_rdata,
  output logic              o_data_rinc,
  input  logic              i_ctl_valid,
  input  logic [DATA_W-1:0] i_ctl_data,
  output logic              o_ctl_ready,
  input  logic              i_rdi_pl_trdy,
  output logic              o_rdi_lp_valid,
  output logic              o_rdi_lp_irdy,
  output logic [DATA_W-1:0] o_rdi_lp_data,
  output logic              o_grant_ctl,
  output logic              o_flit_abort,
  output logic [1:0]        o_dbg_state
);

  localparam int BC_W = beat_cnt_w(FLIT_BEATS);
  localparam int WC_W = wcnt_w(DATA_WEIGHT);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(FLIT_BEATS - 1);

  arb_state_t      state;
  logic [BC_W-1:0] beat_cnt;
  logic [WC_W-1:0] wcnt;
  logic [WC_W-1:0] wcnt_nxt;
  logic            flit_abort_q;
  logic            link_active;
  logic            pick_data;
  logic            pick_ctl;
  logic            xfer;

  assign link_active = (i_fdi_pl_state_sts == UCIE_ACTIVE);

  ucie_ctl_wrr_pick #(
    .DATA_WEIGHT (DATA_WEIGHT),
    .WCNT_W      (WC_W)
  ) u_pick (
    .data_req   (~i_data_rempty),
    .ctl_req    (i_ctl_valid),
    .wcnt       (wcnt),
    .grant_data (pick_data),
    .grant_ctl  (pick_ctl),
    .wcnt_nxt   (wcnt_nxt)
  );

  // RDI side is combinational from the owning source so a beat can move
  // every cycle; everything is gated off the moment the link leaves Active.
  always_comb begin
    o_rdi_lp_valid = 1'b0;
    o_rdi_lp_data  = '0;
    o_data_rinc    = 1'b0;
    o_ctl_ready    = 1'b0;
    o_grant_ctl    = 1'b0;
    if (link_active) begin
      case (state)
        ST_DATA: begin
          o_rdi_lp_valid = ~i_data_rempty;
          if (!i_data_rempty) o_rdi_lp_data = i_data_rdata;
          o_data_rinc    = ~i_data_rempty & i_rdi_pl_trdy;
        end
        ST_CTL: begin
          o_rdi_lp_valid = i_ctl_valid;
          if (i_ctl_valid) o_rdi_lp_data = i_ctl_data;
          o_ctl_ready    = i_rdi_pl_trdy;
          o_grant_ctl    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_rdi_lp_irdy = o_rdi_lp_valid;
  assign xfer          = o_rdi_lp_valid & i_rdi_pl_trdy;
  assign o_flit_abort  = flit_abort_q;
  assign o_dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      wcnt         <= '0;
      flit_abort_q <= 1'b0;
    end else if (!link_active) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      wcnt         <= '0;
      flit_abort_q <= (state != ST_IDLE);
    end else begin
      flit_abort_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          wcnt <= wcnt_nxt;
          if (pick_data)     state <= ST_DATA;
          else if (pick_ctl) state <= ST_CTL;
        end
        ST_DATA, ST_CTL: begin
          // Underrun just stalls here; the grant is held until the flit ends.
          if (xfer) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + BC_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_ctl_tx_arbiter.sv
module tb_ucie_ctl_tx_arbiter;

  localparam int DW = 64;
  localparam int FB = 4;
  localparam int WT = 3;
  localparam logic [3:0] ACT = 4'b0001;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    i_fdi_pl_state_sts;
  logic          i_data_rempty;
  logic [DW-1:0] i_data_rdata;
  logic          o_data_rinc;
  logic          i_ctl_valid;
  logic [DW-1:0] i_ctl_data;
  logic          o_ctl_ready;
  logic          i_rdi_pl_trdy;
  logic          o_rdi_lp_valid;
  logic          o_rdi_lp_irdy;
  logic [DW-1:0] o_rdi_lp_data;
  logic          o_grant_ctl;
  logic          o_flit_abort;
  logic [1:0]    o_dbg_state;

  always #5 clk = ~clk;

  ucie_ctl_tx_arbiter #(
    .DATA_W (DW), .FLIT_BEATS (FB), .DATA_WEIGHT (WT), .UCIE_ACTIVE (ACT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .i_fdi_pl_state_sts (i_fdi_pl_state_sts),
    .i_data_rempty (i_data_rempty), .i_data_rdata (i_data_rdata),
    .o_data_rinc (o_data_rinc),
    .i_ctl_valid (i_ctl_valid), .i_ctl_data (i_ctl_data),
    .o_ctl_ready (o_ctl_ready),
    .i_rdi_pl_trdy (i_rdi_pl_trdy),
    .o_rdi_lp_valid (o_rdi_lp_valid), .o_rdi_lp_irdy (o_rdi_lp_irdy),
    .o_rdi_lp_data (o_rdi_lp_data),
    .o_grant_ctl (o_grant_ctl), .o_flit_abort (o_flit_abort),
    .o_dbg_state (o_dbg_state)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // Beats still in the TX FIFO, in the order RDI must deliver them.
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner of the link: 0 none, 1 data flit, 2 control flit.
  int   m_owner = 0;
  int   m_left  = 0;   // beats still to send in the owned flit
  int   m_run   = 0;   // data flits granted back-to-back while control waited
  logic m_abort = 1'b0;

  // Stimulus knobs set by the sequences before each cycle.
  logic          t_rst_n  = 1'b1;
  logic [3:0]    t_sts    = ACT;
  logic          t_cvalid = 1'b0;
  logic [DW-1:0] t_cdata  = '0;
  logic          t_trdy   = 1'b1;

  // DUT outputs seen in the last cycle, for sequence-level counting.
  logic d_valid, d_rinc, d_ready, d_grant, d_abort;

  task automatic cycle();
    logic          empty, active;
    logic [DW-1:0] rdata;
    logic          e_valid, e_rinc, e_ready, e_grant;
    logic [DW-1:0] e_data;
    @(negedge clk);
    empty = (exp_q.size() == 0);
    rdata = empty ? {$urandom, $urandom} : exp_q[0];
    rst_n              = t_rst_n;
    i_fdi_pl_state_sts = t_sts;
    i_data_rempty      = empty;
    i_data_rdata       = rdata;
    i_ctl_valid        = t_cvalid;
    i_ctl_data         = t_cdata;
    i_rdi_pl_trdy      = t_trdy;
    #1;
    if (!t_rst_n) begin
      m_owner = 0; m_left = 0; m_run = 0; m_abort = 1'b0;
    end
    active  = t_rst_n && (t_sts == ACT);
    e_valid = 1'b0; e_data = '0; e_rinc = 1'b0; e_ready = 1'b0; e_grant = 1'b0;
    if (active && m_owner == 1) begin
      e_valid = !empty;
      e_data  = empty ? '0 : rdata;
      e_rinc  = !empty && t_trdy;
    end
    if (active && m_owner == 2) begin
      e_valid = t_cvalid;
      e_data  = t_cvalid ? t_cdata : '0;
      e_ready = t_trdy;
      e_grant = 1'b1;
    end
    chk("valid", o_rdi_lp_valid, e_valid);
    chk("irdy", o_rdi_lp_irdy, e_valid);
    chk("data", o_rdi_lp_data, e_data);
    chk("rinc", o_data_rinc, e_rinc);
    chk("ctl_ready", o_ctl_ready, e_ready);
    chk("grant_ctl", o_grant_ctl, e_grant);
    chk("flit_abort", o_flit_abort, m_abort);
    chk("dbg_state", o_dbg_state, m_owner);
    d_valid = o_rdi_lp_valid; d_rinc = o_data_rinc; d_ready = o_ctl_ready;
    d_grant = o_grant_ctl;    d_abort = o_flit_abort;
    // advance the model to the next cycle
    if (t_rst_n) begin
      if (t_sts != ACT) begin
        m_abort = (m_owner != 0);
        m_owner = 0; m_left = 0; m_run = 0;
      end else begin
        m_abort = 1'b0;
        if (m_owner == 0) begin
          // Data goes unless control is waiting and WT data flits already went.
          if (!empty && (!t_cvalid || m_run < WT)) begin
            m_owner = 1; m_left = FB;
            if (t_cvalid) m_run++;
          end else if (t_cvalid) begin
            m_owner = 2; m_left = FB; m_run = 0;
          end
        end else if (e_valid && t_trdy) begin
          m_left--;
          if (m_left == 0) m_owner = 0;
        end
      end
    end
    if (e_rinc) void'(exp_q.pop_front());
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [3:0]    sts;
    logic          cv;
    logic [DW-1:0] cd;
    logic          trdy;
    logic          rempty;
    logic [DW-1:0] rd;
    logic          valid;
    logic [DW-1:0] data;
    logic          rinc;
    logic          ready;
    logic          grant;
    logic          abort;
  } vec_t;

  vec_t vecs[10];

  // ---------------- test ----------------
  initial begin
    int    n, cnt, cnt2, flits, beats, started;
    string got_order, exp_order;

    // Control flit from IDLE with a stall, an underrun, then a link exit
    // landing on the last beat; wcnt and state start from reset.
    vecs[0] = '{4'h0, 1'b1, 64'hA0, 1'b1, 1'b1, 64'h0,  1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{ACT,  1'b1, 64'hA1, 1'b1, 1'b1, 64'h0,  1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{ACT,  1'b1, 64'hA2, 1'b0, 1'b1, 64'h0,  1'b1, 64'hA2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{ACT,  1'b1, 64'hA3, 1'b1, 1'b1, 64'h0,  1'b1, 64'hA3, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{ACT,  1'b0, 64'hA4, 1'b1, 1'b1, 64'h0,  1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{ACT,  1'b1, 64'hA5, 1'b1, 1'b0, 64'hD0, 1'b1, 64'hA5, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{ACT,  1'b1, 64'hA6, 1'b1, 1'b1, 64'h0,  1'b1, 64'hA6, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{4'h3, 1'b1, 64'hA7, 1'b1, 1'b1, 64'h0,  1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{4'h3, 1'b1, 64'hA8, 1'b1, 1'b1, 64'h0,  1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{4'h3, 1'b1, 64'hA9, 1'b1, 1'b1, 64'h0,  1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0};

    // reset state with every request asserted
    rst_n = 1'b0; i_fdi_pl_state_sts = ACT; i_data_rempty = 1'b0;
    i_data_rdata = 64'h1234; i_ctl_valid = 1'b1; i_ctl_data = 64'h5678;
    i_rdi_pl_trdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", o_rdi_lp_valid, 1'b0);
    chk("rst_irdy", o_rdi_lp_irdy, 1'b0);
    chk("rst_data", o_rdi_lp_data, '0);
    chk("rst_rinc", o_data_rinc, 1'b0);
    chk("rst_ready", o_ctl_ready, 1'b0);
    chk("rst_grant", o_grant_ctl, 1'b0);
    chk("rst_abort", o_flit_abort, 1'b0);
    chk("rst_state", o_dbg_state, 2'b00);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      i_fdi_pl_state_sts = vecs[i].sts;
      i_ctl_valid = vecs[i].cv;     i_ctl_data = vecs[i].cd;
      i_rdi_pl_trdy = vecs[i].trdy; i_data_rempty = vecs[i].rempty;
      i_data_rdata = vecs[i].rd;
      #1;
      chk($sformatf("vec%0d_valid", i), o_rdi_lp_valid, vecs[i].valid);
      chk($sformatf("vec%0d_data", i), o_rdi_lp_data, vecs[i].data);
      chk($sformatf("vec%0d_rinc", i), o_data_rinc, vecs[i].rinc);
      chk($sformatf("vec%0d_ready", i), o_ctl_ready, vecs[i].ready);
      chk($sformatf("vec%0d_grant", i), o_grant_ctl, vecs[i].grant);
      chk($sformatf("vec%0d_abort", i), o_flit_abort, vecs[i].abort);
    end

    // reset asserted during beat 2 of a control flit, then a data release
    t_sts = ACT; t_cvalid = 1'b1; t_trdy = 1'b1;
    repeat (3) cycle();   // decide, beat 0, beat 1
    t_rst_n = 1'b0;
    cycle();              // beat 2 cut by reset, outputs must already be 0
    cycle();
    for (int i = 0; i < 4; i++) exp_q.push_back({$urandom, $urandom});
    t_cvalid = 1'b0; t_rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(); n++;
      if (d_valid) break;
    end
    chk("rst_release_latency", n, 2);
    for (int k = 0; k < 20 && (m_owner != 0 || exp_q.size() != 0); k++) cycle();

    // data only: 8 beats, two flits with one bubble
    for (int i = 0; i < 8; i++) exp_q.push_back({$urandom, $urandom});
    cnt = 0; cnt2 = 0;
    repeat (12) begin
      cycle();
      if (d_rinc) cnt++;
      if (d_grant) cnt2++;
    end
    chk("data_only_rinc_cycles", cnt, 8);
    chk("data_only_grant_ctl", cnt2, 0);

    // fairness: both sources always pending
    t_cvalid = 1'b1; t_trdy = 1'b1;
    flits = 0; beats = 0; got_order = "";
    for (int k = 0; k < 120 && flits < 8; k++) begin
      if (exp_q.size() < 2) exp_q.push_back({$urandom, $urandom});
      t_cdata = {$urandom, $urandom};
      cycle();
      if (d_valid) begin
        beats++;
        if (beats % FB == 0) begin
          got_order = {got_order, d_grant ? "C" : "D"};
          flits++;
        end
      end
    end
    chk("fair_flits", flits, 8);
    exp_order = "DDDCDDDC";
    for (int i = 0; i < 8; i++)
      chk($sformatf("fair_order%0d", i), got_order[i], exp_order[i]);

    // backpressure and FIFO underrun inside a data flit, control waiting
    exp_q.delete();
    for (int i = 0; i < 2; i++) exp_q.push_back({$urandom, $urandom});
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 60 && m_owner != 2; k++) begin
      t_trdy = (k % 2 == 0);
      t_cdata = {$urandom, $urandom};
      if (k == 12) for (int i = 0; i < 2; i++) exp_q.push_back({$urandom, $urandom});
      cycle();
      if (d_rinc) cnt++;
      if (d_ready || d_grant) cnt2++;
    end
    chk("bp_data_xfers", cnt, 4);
    chk("bp_ctl_interleave", cnt2, 0);

    // link exit after beat 2 of the control flit that was just granted
    t_trdy = 1'b1;
    repeat (3) cycle();
    t_sts = 4'b0011;
    cycle();
    chk("exit_valid", d_valid, 1'b0);
    cycle();
    chk("exit_abort", d_abort, 1'b1);
    cycle();
    chk("exit_abort_once", d_abort, 1'b0);
    t_sts = ACT;
    cnt = 0; started = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (d_valid && t_trdy) cnt++;
      if (m_owner != 0) started = 1;
      else if (started != 0) break;
    end
    chk("exit_restart_beats", cnt, 4);

    // link exit in the same cycle as the last control beat
    repeat (4) cycle();   // decide, beats 0..2
    t_sts = 4'b0000;
    cycle();
    chk("sim_exit_ready", d_ready, 1'b0);
    cycle();
    chk("sim_exit_abort", d_abort, 1'b1);
    t_sts = ACT;

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      t_sts    = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : ACT;
      t_trdy   = ($urandom_range(0, 3) != 0);
      t_cvalid = ($urandom_range(0, 2) == 0);
      t_cdata  = {$urandom, $urandom};
      t_rst_n  = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) == 0 && exp_q.size() < 8) exp_q.push_back({$urandom, $urandom});
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
